// File: rtl/upsample_pkg.sv
// Shared types and widths for the 4:2:0 -> 4:4:4 chroma upsampler.
package upsample_pkg;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 11;
    localparam int PIX_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/chroma_upsample_linebuf.sv
// One chroma row of storage: simple dual-port RAM with a registered read port.
module chroma_upsample_linebuf #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/chroma_upsample.sv
// Nearest-neighbour chroma upsampler: each 4:2:0 sample becomes a 2x2 block of 4:4:4 pixels,
// odd output rows are replayed from a line buffer written during the preceding even row.
module chroma_upsample
    import upsample_pkg::*;
#(
    parameter int MAX_WIDTH = 1024
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             err_tlast
);
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state;
    logic [DIM_W-1:0] w, h, x, row;
    logic [PIX_W-1:0] hold, byp_data, ram_q, rd_pix, new_pix, pix;
    logic             byp_valid;
    logic [DIM_W-1:0] x_half, x_next_half;
    logic [AW-1:0]    waddr, raddr;
    logic             out_free, in_fire, fire, row_end, more_rows, in_last_col;

    // Valid/ready: a beat transfers on any rising edge where valid & ready are both 1.
    // The output register refills only when it is empty or its beat transfers this cycle,
    // and a stalled beat (valid=1, ready=0) keeps data/tlast/tuser unchanged.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_FILL) && !x[0] && out_free;
    assign in_fire       = s_axis_tvalid && s_axis_tready;

    always_comb begin
        fire = 1'b0;
        if (state == ST_FILL)        fire = x[0] ? out_free : in_fire;
        else if (state == ST_REPLAY) fire = out_free;
    end

    assign row_end     = (x == w - DIM_W'(1));
    assign more_rows   = ((row + DIM_W'(1)) < h);
    assign x_half      = x >> 1;
    assign x_next_half = (x + DIM_W'(1)) >> 1;
    assign in_last_col = (x_half == ((w - DIM_W'(1)) >> 1));

    // Replay address always points at the next even pixel's sample, so the registered
    // read is ready before it is needed, including on the first replay pixel.
    assign waddr = x_half[AW-1:0];
    assign raddr = (state == ST_REPLAY) ? x_next_half[AW-1:0] : '0;

    // A one-sample-wide row writes and re-reads address 0 in the same cycle.
    assign rd_pix  = byp_valid ? byp_data : ram_q;
    assign new_pix = (state == ST_FILL) ? s_axis_tdata : rd_pix;
    assign pix     = x[0] ? hold : new_pix;
    assign ap_idle = (state == ST_IDLE);

    chroma_upsample_linebuf #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_linebuf (
        .clk   (ap_clk),
        .we    (in_fire),
        .waddr (waddr),
        .wdata (s_axis_tdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state         <= ST_IDLE;
            w             <= '0;
            h             <= '0;
            x             <= '0;
            row           <= '0;
            hold          <= '0;
            byp_valid     <= 1'b0;
            byp_data      <= '0;
            ap_done       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            err_tlast     <= 1'b0;
        end else begin
            ap_done   <= 1'b0;
            byp_valid <= in_fire && (waddr == raddr);
            byp_data  <= s_axis_tdata;
            if (out_free) m_axis_tvalid <= fire;
            if (fire) begin
                m_axis_tdata <= pix;
                m_axis_tlast <= row_end;
                m_axis_tuser <= (x == '0) && (row == '0);
                if (!x[0]) hold <= new_pix;
            end
            if (in_fire && (s_axis_tlast != in_last_col)) err_tlast <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        w     <= cfg_width;
                        h     <= cfg_height;
                        x     <= '0;
                        row   <= '0;
                        state <= ST_FILL;
                    end
                end
                ST_FILL, ST_REPLAY: begin
                    if (fire) begin
                        if (row_end) begin
                            x <= '0;
                            if (more_rows) begin
                                row   <= row + DIM_W'(1);
                                state <= (state == ST_FILL) ? ST_REPLAY : ST_FILL;
                            end else begin
                                state <= ST_DONE;
                            end
                        end else begin
                            x <= x + DIM_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Last beat sits in the output register until it transfers.
                    if (out_free) begin
                        ap_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chroma_upsample.sv
// Bench for chroma_upsample: random chroma frames checked against a 2x2 replication model.
module tb_chroma_upsample;
    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_idle, ap_done;
    logic [10:0] cfg_width = '0, cfg_height = '0;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser;
    logic        err_tlast;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;
    logic [15:0] in_q[$];
    logic [17:0] exp_q[$];

    chroma_upsample dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_done(ap_done), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    // Model: pixel (x,y) carries chroma sample (y/2, x/2); tuser/tlast from position only.
    task automatic build_frame(input int w, input int h);
        int cw = (w + 1) / 2;
        int ch = (h + 1) / 2;
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < cw * ch; i++) in_q.push_back(16'($urandom));
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back({(x == 0 && y == 0), (x == w - 1), in_q[(y / 2) * cw + x / 2]});
    endtask

    task automatic drive_inputs(input int w, input int vgap, input int bad_idx);
        int cw = (w + 1) / 2;
        int n = in_q.size();
        int i = 0;
        int budget = 0;
        while (i < n && budget < 5000) begin
            @(negedge clk);
            checks++;
            if (err_tlast !== exp_err) begin
                errors++;
                $display("FAIL err_tlast_track: got %0b want %0b", err_tlast, exp_err);
            end
            s_axis_tvalid = (vgap == 0) || ($urandom_range(0, 3) != 0);
            s_axis_tdata  = in_q[i];
            s_axis_tlast  = ((i % cw) == cw - 1) ^ (i == bad_idx);
            #4;
            if (s_axis_tvalid && s_axis_tready) begin
                if (i == bad_idx) exp_err = 1'b1;
                i++;
            end
            budget++;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        checks++;
        if (i < n || err_tlast !== exp_err) begin
            errors++;
            $display("FAIL input_drain: accepted %0d of %0d, err_tlast %0b want %0b", i, n, err_tlast, exp_err);
        end
    endtask

    task automatic collect(input int w, input int h, input int rmode);
        int n = w * h;
        int got = 0;
        int budget = 0;
        int p;
        bit prev_stall = 1'b0;
        logic [17:0] prev = '0;
        logic [17:0] obs, exp;
        while (got < n && budget < 10000) begin
            @(negedge clk);
            m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
            #4;
            obs = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            checks++;
            if (ap_idle !== 1'b0) begin
                errors++;
                $display("FAIL idle_in_frame: ap_idle %0b want 0", ap_idle);
            end
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || obs !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h", m_axis_tvalid, obs, prev);
                end
            end
            if (s_axis_tready === 1'b1) begin
                // The next pixel loaded must start a sample pair in an even row.
                p = got + int'(m_axis_tvalid);
                checks++;
                if ((m_axis_tvalid && !m_axis_tready) || p >= n || ((p / w) % 2) != 0 || ((p % w) % 2) != 0) begin
                    errors++;
                    $display("FAIL in_ready_phase: ready=1 at pixel %0d (w=%0d) want 0", p, w);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL out_beat[%0d]: got %h want %h", got, obs, exp);
                end
                got++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev = obs;
            budget++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL out_count: got %0d beats want %0d", got, n);
        end
    endtask

    task automatic wait_done(input bit chain, input int nw, input int nh);
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m_axis_tready = 1'b1;
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL extra_beat: m_axis_tvalid %0b want 0", m_axis_tvalid);
            end
            if (ap_done === 1'b1) begin
                seen++;
                checks++;
                if (ap_idle !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_at_done: ap_idle %0b want 1", ap_idle);
                end
                if (chain) begin
                    ap_start = 1'b1;
                    cfg_width = 11'(nw);
                    cfg_height = 11'(nh);
                    break;
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL done_pulse: seen %0d want 1", seen);
        end
    endtask

    task automatic run_frame(input int w, input int h, input int rmode, input int vgap, input int bad_idx,
                             input bit pre_started, input bit chain, input int nw, input int nh);
        build_frame(w, h);
        if (!pre_started) begin
            @(negedge clk);
            ap_start = 1'b1;
            cfg_width = 11'(w);
            cfg_height = 11'(h);
        end
        @(negedge clk);
        ap_start = 1'b0;
        checks++;
        if (ap_idle !== 1'b0) begin
            errors++;
            $display("FAIL start_idle: ap_idle %0b want 0", ap_idle);
        end
        fork
            drive_inputs(w, vgap, bad_idx);
            collect(w, h, rmode);
        join
        wait_done(chain, nw, nh);
        checks++;
        if (err_tlast !== exp_err) begin
            errors++;
            $display("FAIL err_tlast_end: got %0b want %0b", err_tlast, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({ap_idle, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_tlast}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: idle=%0b done=%0b srdy=%0b mv=%0b md=%h ml=%0b mu=%0b err=%0b want 1 0 0 0 0000 0 0 0",
                     tag, ap_idle, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                     m_axis_tuser, err_tlast);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        ap_rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_basic_4x4();
        run_frame(4, 4, 0, 0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_odd_3x3();
        run_frame(3, 3, 0, 0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_stall_toggle();
        run_frame(4, 4, 1, 0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_tlast_err();
        run_frame(4, 4, 0, 0, 2, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int i = 0;
        int got = 0;
        int budget = 0;
        logic [17:0] exp;
        build_frame(8, 4);
        @(negedge clk);
        ap_start = 1'b1;
        cfg_width = 11'd8;
        cfg_height = 11'd4;
        @(negedge clk);
        ap_start = 1'b0;
        while (got < 18 && budget < 200) begin
            @(negedge clk);
            m_axis_tready = 1'b1;
            s_axis_tvalid = (i < in_q.size());
            s_axis_tdata  = (i < in_q.size()) ? in_q[i] : 16'h0;
            s_axis_tlast  = ((i % 4) == 3);
            #4;
            if (s_axis_tvalid && s_axis_tready) i++;
            if (m_axis_tvalid && m_axis_tready) begin
                exp = exp_q.pop_front();
                checks++;
                if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== exp) begin
                    errors++;
                    $display("FAIL pre_abort_beat[%0d]: got %h want %h", got,
                             {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp);
                end
                got++;
            end
            budget++;
        end
        checks++;
        if (got != 18) begin
            errors++;
            $display("FAIL pre_abort_count: got %0d want 18", got);
        end
        @(negedge clk);
        ap_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        ap_rst_n = 1'b1;
        exp_err = 1'b0;
        run_frame(8, 4, 0, 0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(2, 1, 0, 0, -1, 1'b0, 1'b1, 6, 2);
        run_frame(6, 2, 0, 0, -1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int w = (k == 0) ? 1 : $urandom_range(1, 20);
            int h = $urandom_range(1, 7);
            run_frame(w, h, 2, 1, -1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_odd_3x3();
        test_stall_toggle();
        test_tlast_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
